// File: rtl/xbus_pkg.sv
// ---------------------------------------------------------------------------
// xbus_pkg
// Shared xbus definitions used by the initiator and its timeout counter.
//   ADDR_W / DATA_W : xbus word-address and data widths
//   xbus_state_e    : initiator transaction states
//   SPY_BASE        : base word address of the spy responder window
//   spy_match()     : true when an address falls in the 8-word spy window
// ---------------------------------------------------------------------------
package xbus_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] SPY_BASE = 22'o17766000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } xbus_state_e;

  // The spy responder decodes the low three address bits itself, so the
  // window match only looks at the bits above them.
  function automatic logic spy_match(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:3] == SPY_BASE[ADDR_W-1:3];
  endfunction

endpackage

// File: rtl/xbus_timeout.sv
// ---------------------------------------------------------------------------
// xbus_timeout
// Saturating cycle counter used to bound how long the initiator waits for ack.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count one cycle; holds once LIMIT is reached
//   expired    : high while the count equals LIMIT
// Parameters: LIMIT (terminal count), WIDTH (counter width, LIMIT < 2^WIDTH).
// ---------------------------------------------------------------------------
module xbus_timeout #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, otherwise step up but never past LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT_W);

endmodule

// File: rtl/xbus_initiator.sv
// ---------------------------------------------------------------------------
// xbus_initiator
// Single-outstanding xbus master. Accepts one host command at a time, runs
// it as an xbus read or write, reports completion with a one-cycle rsp_valid
// pulse, then waits for the responder's delayed ack to fall before taking
// the next command.
//
// Host side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data in,
//             rsp_valid/rsp_data/rsp_err out.
// Bus side  : req/write/addr/dataout out, datain/ack/decode in.
// Debug     : busy_nodecode, high while BUSY and no responder decodes.
//
// Build option: define XBUS_INITIATOR_TIMEOUT_EN to build the timeout
// counter (TIMEOUT/TWIDTH). Without it BUSY waits for ack indefinitely and
// rsp_err never asserts.
// ---------------------------------------------------------------------------
module xbus_initiator
  import xbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TWIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  // host command / response
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  // xbus
  output logic              req,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataout,
  input  logic [DATA_W-1:0] datain,
  input  logic              ack,
  input  logic              decode,
  output logic              busy_nodecode
);

  xbus_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef XBUS_INITIATOR_TIMEOUT_EN
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // The counter restarts at command acceptance and only runs while the
  // request is outstanding without an ack.
  assign timer_clr = (state_q == IDLE) && cmd_valid;
  assign timer_en  = (state_q == BUSY) && !ack;

  xbus_timeout #(
    .LIMIT (TIMEOUT),
    .WIDTH (TWIDTH)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign timeout_hit = timer_expired;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{TIMEOUT, TWIDTH};
  assign timeout_hit = 1'b0;
`endif

  // Next-state and datapath: bus fields are loaded only on acceptance so
  // they stay stable for the whole request; the response is loaded only
  // when leaving BUSY. Ack is checked before the timeout so a same-cycle
  // ack still completes the transfer cleanly.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    dataout_d  = dataout_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          write_d   = cmd_write;
          dataout_d = cmd_data;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (ack) begin
          rsp_data_d = write_q ? '0 : datain;
          rsp_err_d  = 1'b0;
          state_d    = DONE;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // Responders hold ack for a few cycles after req falls; waiting it
        // out keeps a stale ack from completing the next request early.
        if (!ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      dataout_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      dataout_q  <= dataout_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Control outputs decode straight from the state register, so reset
  // drops req asynchronously and nothing depends combinationally on ack.
  assign cmd_ready     = (state_q == IDLE);
  assign req           = (state_q == BUSY);
  assign rsp_valid     = (state_q == DONE);
  assign write         = write_q;
  assign addr          = addr_q;
  assign dataout       = dataout_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign busy_nodecode = (state_q == BUSY) && !decode;

endmodule
